baud_gen: RTL and testbench

- Parametrised, registered successor to the combinational baud counter.
- Divides `clk` by an integer-plus-fractional divisor to produce an oversample tick (`os_tick`).
- Counts `os_tick`s to produce a bit-centre tick (`mid_tick`) and a bit-end tick (`bit_tick`).
- Sits between the APB register file (divisor/enable) and the UART TX/RX engines. RX uses `resync` to align to a start-bit edge.

---
 rtl/uart_pkg.sv | 12 +
 rtl/baud_frac_acc.sv | 42 ++++
 rtl/baud_gen.sv | 132 +++++++++++++
 tb/tb_baud_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and divisor types used by the baud generator, register file and TX/RX.
package uart_pkg;

    localparam int unsigned BAUD_DIV_W      = 20;
    localparam int unsigned BAUD_FRAC_W     = 4;
    localparam int unsigned BAUD_OVERSAMPLE = 16;
    localparam int unsigned BAUD_MIN_DIV    = 16;

    typedef logic [BAUD_DIV_W-1:0]  baud_div_t;
    typedef logic [BAUD_FRAC_W-1:0] baud_frac_t;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator: each step adds frac and flags a one-clock period extension
// on carry-out.
module baud_frac_acc
    import uart_pkg::*;
#(
    parameter int unsigned FRAC_W = BAUD_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              step,
    input  logic [FRAC_W-1:0] frac,
    output logic              ext
);

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;

    always_comb begin
        acc_d = acc_q;
        ext_d = ext_q;
        if (clr) begin
            acc_d = '0;
            ext_d = 1'b0;
        end else if (step) begin
            {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ext_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ext_q <= ext_d;
        end
    end

    assign ext = ext_q;

endmodule

// File: rtl/baud_gen.sv
// Registered baud generator: os_tick every div_int(+frac) clocks, mid/bit ticks per OVERSAMPLE.
// Fractional divisor support is compiled in only when BAUD_GEN_FRAC_EN is defined.
module baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W      = BAUD_DIV_W,
    parameter int unsigned FRAC_W     = BAUD_FRAC_W,
    parameter int unsigned OVERSAMPLE = BAUD_OVERSAMPLE,
    parameter int unsigned MIN_DIV    = BAUD_MIN_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              resync,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              active
);

    localparam int unsigned     OS_W   = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] MidIdx = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] BitIdx = OS_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] sh_int_q, sh_int_d;
    logic [DIV_W-1:0] cur_int;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic             os_tick_q, os_tick_d;
    logic             mid_tick_q, mid_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             active_q, active_d;
    logic             valid, clr, ext, period_end, last;

    assign valid = (div_int >= DIV_W'(MIN_DIV));
    assign clr   = !en || !valid || resync;

    // On the first counting edge after idle the shadow may still hold an out-of-range value
    // captured while idle, so the live port value is used for that single comparison.
    assign cur_int = active_q ? sh_int_q : div_int;

    // Compare against P-1 without forming sh_int+ext, which could overflow DIV_W.
    assign period_end = ext ? (cnt_q == cur_int) : (cnt_q == cur_int - 1'b1);
    assign last       = !clr && period_end;

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;

    assign sh_frac_d = (clr || !active_q || last) ? div_frac : sh_frac_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_frac_q <= '0;
        end else begin
            sh_frac_q <= sh_frac_d;
        end
    end

    baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .step (last),
        .frac (sh_frac_q),
        .ext  (ext)
    );
`else
    logic unused_div_frac;
    assign unused_div_frac = ^div_frac;
    assign ext             = 1'b0;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        sh_int_d   = sh_int_q;
        os_tick_d  = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;
        active_d   = 1'b1;
        if (clr) begin
            cnt_d    = '0;
            os_cnt_d = '0;
            sh_int_d = div_int;
            active_d = en && valid;
        end else begin
            if (!active_q) begin
                sh_int_d = div_int;
            end
            if (last) begin
                cnt_d      = '0;
                os_tick_d  = 1'b1;
                mid_tick_d = (os_cnt_q == MidIdx);
                bit_tick_d = (os_cnt_q == BitIdx);
                os_cnt_d   = os_cnt_q + 1'b1;
                sh_int_d   = div_int;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            os_cnt_q   <= '0;
            sh_int_q   <= '0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            os_cnt_q   <= os_cnt_d;
            sh_int_q   <= sh_int_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
            active_q   <= active_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign mid_tick = mid_tick_q;
    assign bit_tick = bit_tick_q;
    assign active   = active_q;

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen against a tick-schedule reference model.
module tb_baud_gen;
    import uart_pkg::*;

    localparam int unsigned OS = BAUD_OVERSAMPLE;
`ifdef BAUD_GEN_FRAC_EN
    localparam bit FracEn = 1'b1;
`else
    localparam bit FracEn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst, en, resync;
    logic [BAUD_DIV_W-1:0]  div_int;
    logic [BAUD_FRAC_W-1:0] div_frac;
    logic                   os_tick, mid_tick, bit_tick, active;

    baud_gen dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_int  (div_int),
        .div_frac (div_frac),
        .resync   (resync),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick),
        .active   (active)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    // Reference model: a period begins with a length chosen from the divisor seen at that
    // moment; edges are counted down and a tick fires on the last one.
    bit          running = 1'b0;
    int unsigned rem, per_div, per_frac, os_idx, frac_total;
    bit          e_os = 1'b0, e_mid = 1'b0, e_bit = 1'b0, e_act = 1'b0;

    task automatic start_fresh();
        per_div    = int'(div_int);
        per_frac   = int'(div_frac);
        rem        = per_div;
        os_idx     = 0;
        frac_total = 0;
    endtask

    task automatic model_edge();
        int unsigned ext;
        e_os  = 1'b0;
        e_mid = 1'b0;
        e_bit = 1'b0;
        if (rst || !en || int'(div_int) < int'(BAUD_MIN_DIV)) begin
            running = 1'b0;
            e_act   = 1'b0;
        end else if (resync) begin
            running = 1'b1;
            e_act   = 1'b1;
            start_fresh();
        end else begin
            if (!running) begin
                running = 1'b1;
                start_fresh();
            end
            e_act = 1'b1;
            rem   = rem - 1;
            if (rem == 0) begin
                e_os  = 1'b1;
                e_mid = ((os_idx % OS) == OS / 2 - 1);
                e_bit = ((os_idx % OS) == OS - 1);
                os_idx++;
                ext = FracEn ? (((frac_total + per_frac) >> BAUD_FRAC_W)
                               - (frac_total >> BAUD_FRAC_W)) : 0;
                frac_total += per_frac;
                per_div  = int'(div_int);
                per_frac = int'(div_frac);
                rem      = per_div + ext;
            end
        end
    endtask

    task automatic check();
        n_cmp++;
        assert (os_tick === e_os) else begin
            n_fail++;
            $error("FAIL os_tick t=%0t got %b want %b", $time, os_tick, e_os);
        end
        n_cmp++;
        assert (mid_tick === e_mid) else begin
            n_fail++;
            $error("FAIL mid_tick t=%0t got %b want %b", $time, mid_tick, e_mid);
        end
        n_cmp++;
        assert (bit_tick === e_bit) else begin
            n_fail++;
            $error("FAIL bit_tick t=%0t got %b want %b", $time, bit_tick, e_bit);
        end
        n_cmp++;
        assert (active === e_act) else begin
            n_fail++;
            $error("FAIL active t=%0t got %b want %b", $time, active, e_act);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_resync();
        resync = 1'b1;
        cycle();
        resync = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        resync   = 1'b0;
        div_int  = 20'd16;
        div_frac = '0;
        run(3);

        // Plain divide-by-16 for several bits.
        rst = 1'b0;
        en  = 1'b1;
        run(800);

        // Half-clock fraction.
        div_frac = 4'd8;
        run(600);
        div_frac = '0;

        // Below minimum holds idle, then a legal divisor starts counting.
        div_int = 20'd15;
        run(50);
        div_int = 20'd16;
        run(300);

        // Divisor change part-way through a period.
        div_int = 20'd20;
        pulse_resync();
        run(5);
        div_int = 20'd40;
        run(1500);

        // Resync part-way through a bit, then idle-to-count after en drop and reset.
        div_int = 20'd18;
        run(11 * 18 + 3);
        pulse_resync();
        run(400);
        en = 1'b0;
        cycle();
        en = 1'b1;
        run(300);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(300);

        // Largest divisor: counting without overflow.
        div_int  = {BAUD_DIV_W{1'b1}};
        div_frac = 4'hf;
        pulse_resync();
        run(200);

        // Randomised mix of divisors, fractions, resyncs, enable drops and resets.
        div_int = 20'd16;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 99) == 0) div_int = 20'($urandom_range(13, 40));
            if ($urandom_range(0, 49) == 0) div_frac = 4'($urandom_range(0, 15));
            resync = ($urandom_range(0, 299) == 0);
            en     = ($urandom_range(0, 699) != 0);
            rst    = ($urandom_range(0, 1499) == 0);
            cycle();
        end
        resync = 1'b0;
        en     = 1'b1;
        rst    = 1'b0;
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
